motor_cmd_scheduler: RTL and testbench

Per-axis command scheduler between the UART command parser and the 10 motor_ctrl step generators. Buffers up to two motion commands per axis and loads each one into its step generator when the previous move finishes. Aborts a move and flushes that axis when its limit switch trips. Reports per-axis busy/full status for the UART status reply.

---
 rtl/motor_cmd_scheduler.sv | 206 ++++++++++++++++++++
 tb/tb_motor_cmd_scheduler.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/motor_cmd_scheduler.sv
// Per-axis motion command scheduler: a 2-deep command queue plus a load/run FSM per
// motor_ctrl step generator, with limit-switch abort and generator start timeout.
module motor_cmd_scheduler #(
   parameter int NUM_MOTORS = 10,
   parameter int DIV_W      = 16,
   parameter int STEP_W     = 11,
   parameter int START_TO   = 255
) (
   input  logic                         CLOCK_25,
   input  logic                         reset_n,
   input  logic                         cmd_valid,
   output logic                         cmd_ready,
   input  logic [3:0]                   cmd_motor,
   input  logic [DIV_W-1:0]             cmd_divider,
   input  logic [STEP_W-1:0]            cmd_steps,
   input  logic                         cmd_dir,
   input  logic                         cmd_stop_on_term,
   input  logic [NUM_MOTORS-1:0]        term_n,
   input  logic [NUM_MOTORS-1:0]        mr_active,
   output logic [NUM_MOTORS-1:0]        mr_reset,
   output logic [NUM_MOTORS*DIV_W-1:0]  mr_divider,
   output logic [NUM_MOTORS*STEP_W-1:0] mr_steps,
   output logic [NUM_MOTORS-1:0]        mr_dir,
   output logic [NUM_MOTORS-1:0]        axis_busy,
   output logic [NUM_MOTORS-1:0]        axis_full,
   output logic [NUM_MOTORS-1:0]        abort_pulse,
   output logic                         err_pulse
);
   localparam int EW = DIV_W + STEP_W + 2;
   localparam int TW = $clog2(START_TO + 1);

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_t;

   logic                  r_live;
   logic                  r_err;
   logic [NUM_MOTORS-1:0] r_term_s1;
   logic [NUM_MOTORS-1:0] r_term_s2;
   logic [NUM_MOTORS-1:0] w_push;
   logic [NUM_MOTORS-1:0] w_tmo_err;
   logic                  w_bad_idx;
   logic                  w_sel_full;
   logic                  w_accept;
   logic [EW-1:0]         w_cmd_entry;

   assign w_cmd_entry = {cmd_divider, cmd_steps, cmd_dir, cmd_stop_on_term};
   assign w_bad_idx   = ({1'b0, cmd_motor} >= 5'(NUM_MOTORS));

   always_comb begin
      w_sel_full = 1'b0;
      for (int i = 0; i < NUM_MOTORS; i++) begin
         if (cmd_motor == 4'(i)) w_sel_full = axis_full[i];
      end
   end

   // r_live keeps cmd_ready low while reset is held so every output reads 0.
   assign cmd_ready = r_live && (w_bad_idx || !w_sel_full);
   assign w_accept  = cmd_valid && cmd_ready;
   assign err_pulse = r_err;

   always_ff @(posedge CLOCK_25 or negedge reset_n) begin
      if (!reset_n) begin
         r_live    <= 1'b0;
         r_err     <= 1'b0;
         r_term_s1 <= '1;
         r_term_s2 <= '1;
      end else begin
         r_live    <= 1'b1;
         r_err     <= (w_accept && w_bad_idx) || (|w_tmo_err);
         r_term_s1 <= term_n;
         r_term_s2 <= r_term_s1;
      end
   end

   for (genvar g = 0; g < NUM_MOTORS; g++) begin : g_axis
      state_t            r_state;
      state_t            w_next;
      logic [EW-1:0]     r_q0;
      logic [EW-1:0]     r_q1;
      logic [1:0]        r_cnt;
      logic [TW-1:0]     r_tmo;
      logic              r_act_d;
      logic [DIV_W-1:0]  r_div;
      logic [STEP_W-1:0] r_steps;
      logic              r_dir;
      logic              r_rst;
      logic              r_abort;
      logic              w_pop;
      logic              w_flush;
      logic              w_load;
      logic              w_clear;
      logic              w_abort;
      logic              w_tmo;
      logic [STEP_W-1:0] w_head_steps;
      logic              w_head_stop;

      assign w_head_steps = r_q0[STEP_W+1:2];
      assign w_head_stop  = r_q0[0];
      assign w_push[g]    = w_accept && !w_bad_idx && (cmd_motor == 4'(g));
      assign w_tmo_err[g] = w_tmo;

      // Abort is tested before the active fall so a limit hit always flushes the queue.
      always_comb begin
         w_next  = r_state;
         w_pop   = 1'b0;
         w_flush = 1'b0;
         w_load  = 1'b0;
         w_clear = 1'b0;
         w_abort = 1'b0;
         w_tmo   = 1'b0;
         case (r_state)
            S_IDLE: begin
               if (r_cnt != 2'd0) begin
                  if (w_head_steps == '0) begin
                     w_pop = 1'b1;
                  end else begin
                     w_load = 1'b1;
                     w_next = S_LOAD;
                  end
               end
            end
            S_LOAD: begin
               if (mr_active[g]) begin
                  w_next = S_RUN;
               end else if (r_tmo == TW'(START_TO - 1)) begin
                  w_tmo   = 1'b1;
                  w_pop   = 1'b1;
                  w_clear = 1'b1;
                  w_next  = S_IDLE;
               end
            end
            S_RUN: begin
               if (w_head_stop && !r_term_s2[g]) begin
                  w_abort = 1'b1;
                  w_flush = 1'b1;
                  w_clear = 1'b1;
                  w_next  = S_DONE;
               end else if (r_act_d && !mr_active[g]) begin
                  w_pop   = 1'b1;
                  w_clear = 1'b1;
                  w_next  = S_DONE;
               end
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
         endcase
      end

      always_ff @(posedge CLOCK_25 or negedge reset_n) begin
         if (!reset_n) begin
            r_state <= S_IDLE;
            r_q0    <= '0;
            r_q1    <= '0;
            r_cnt   <= 2'd0;
            r_tmo   <= '0;
            r_act_d <= 1'b0;
            r_div   <= '0;
            r_steps <= '0;
            r_dir   <= 1'b0;
            r_rst   <= 1'b0;
            r_abort <= 1'b0;
         end else begin
            r_state <= w_next;
            r_act_d <= mr_active[g];
            r_rst   <= w_abort;
            r_abort <= w_abort;
            if (w_load) begin
               r_div   <= r_q0[EW-1 -: DIV_W];
               r_steps <= w_head_steps;
               r_dir   <= r_q0[1];
               r_tmo   <= '0;
            end else begin
               if (w_clear) r_steps <= '0;
               if (r_state == S_LOAD) r_tmo <= r_tmo + TW'(1);
            end
            // A push landing on a flush survives as the only entry.
            if (w_flush) begin
               r_cnt <= {1'b0, w_push[g]};
               if (w_push[g]) r_q0 <= w_cmd_entry;
            end else if (w_push[g] && w_pop) begin
               if (r_cnt == 2'd2) begin
                  r_q0 <= r_q1;
                  r_q1 <= w_cmd_entry;
               end else begin
                  r_q0 <= w_cmd_entry;
               end
            end else if (w_pop) begin
               r_q0  <= r_q1;
               r_cnt <= r_cnt - 2'd1;
            end else if (w_push[g]) begin
               if (r_cnt == 2'd0) r_q0 <= w_cmd_entry;
               else               r_q1 <= w_cmd_entry;
               r_cnt <= r_cnt + 2'd1;
            end
         end
      end

      assign mr_reset[g]                     = r_rst;
      assign abort_pulse[g]                  = r_abort;
      assign mr_divider[g*DIV_W +: DIV_W]    = r_div;
      assign mr_steps[g*STEP_W +: STEP_W]    = r_steps;
      assign mr_dir[g]                       = r_dir;
      assign axis_busy[g]                    = (r_cnt != 2'd0) || (r_state != S_IDLE);
      assign axis_full[g]                    = (r_cnt == 2'd2);
   end

endmodule

// File: tb/tb_motor_cmd_scheduler.sv
// Directed self-checking bench for motor_cmd_scheduler; the bench itself plays the
// role of the step generators by driving mr_active and term_n by hand.
module tb_motor_cmd_scheduler;
   localparam int NM = 10;
   localparam int DW = 16;
   localparam int SW = 11;

   logic            CLOCK_25 = 1'b0;
   logic            reset_n = 1'b1;
   logic            cmd_valid = 1'b0;
   logic            cmd_ready;
   logic [3:0]      cmd_motor = 4'd0;
   logic [DW-1:0]   cmd_divider = '0;
   logic [SW-1:0]   cmd_steps = '0;
   logic            cmd_dir = 1'b0;
   logic            cmd_stop_on_term = 1'b0;
   logic [NM-1:0]   term_n = '1;
   logic [NM-1:0]   mr_active = '0;
   logic [NM-1:0]   mr_reset;
   logic [NM*DW-1:0] mr_divider;
   logic [NM*SW-1:0] mr_steps;
   logic [NM-1:0]   mr_dir;
   logic [NM-1:0]   axis_busy;
   logic [NM-1:0]   axis_full;
   logic [NM-1:0]   abort_pulse;
   logic            err_pulse;

   int n_cmp = 0;
   int n_bad = 0;

   motor_cmd_scheduler #(
      .NUM_MOTORS(NM), .DIV_W(DW), .STEP_W(SW), .START_TO(255)
   ) dut (
      .CLOCK_25(CLOCK_25), .reset_n(reset_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_motor(cmd_motor),
      .cmd_divider(cmd_divider), .cmd_steps(cmd_steps), .cmd_dir(cmd_dir),
      .cmd_stop_on_term(cmd_stop_on_term), .term_n(term_n), .mr_active(mr_active),
      .mr_reset(mr_reset), .mr_divider(mr_divider), .mr_steps(mr_steps), .mr_dir(mr_dir),
      .axis_busy(axis_busy), .axis_full(axis_full), .abort_pulse(abort_pulse),
      .err_pulse(err_pulse)
   );

   always #5 CLOCK_25 = ~CLOCK_25;

   function automatic logic [SW-1:0] stepsOf(input int i);
      return mr_steps[i*SW +: SW];
   endfunction

   function automatic logic [DW-1:0] divOf(input int i);
      return mr_divider[i*DW +: DW];
   endfunction

   task automatic tick();
      @(posedge CLOCK_25);
      #1;
   endtask

   // Offers one command and returns just after the edge that accepted it.
   task automatic send(input int m, input logic [DW-1:0] d, input logic [SW-1:0] s,
                       input logic dr, input logic st);
      int w;
      cmd_motor        = 4'(m);
      cmd_divider      = d;
      cmd_steps        = s;
      cmd_dir          = dr;
      cmd_stop_on_term = st;
      cmd_valid        = 1'b1;
      w = 0;
      while (!cmd_ready && w < 1000) begin
         tick();
         w++;
      end
      n_cmp++;
      if (cmd_ready !== 1'b1) begin n_bad++; $display("[TB] FAIL send_ready axis %0d: got %b want 1", m, cmd_ready); end
      tick();
      cmd_valid = 1'b0;
   endtask

   task automatic test_reset();
      #2 reset_n = 1'b0;
      #1;
      n_cmp++; if (mr_steps !== '0) begin n_bad++; $display("[TB] FAIL rst_steps: got %0h want 0", mr_steps); end
      n_cmp++; if (cmd_ready !== 1'b0) begin n_bad++; $display("[TB] FAIL rst_ready: got %b want 0", cmd_ready); end
      n_cmp++; if (axis_busy !== '0) begin n_bad++; $display("[TB] FAIL rst_busy: got %0h want 0", axis_busy); end
      n_cmp++; if (err_pulse !== 1'b0) begin n_bad++; $display("[TB] FAIL rst_err: got %b want 0", err_pulse); end
      repeat (3) @(posedge CLOCK_25);
      #1 reset_n = 1'b1;
      tick();
      n_cmp++; if (cmd_ready !== 1'b1) begin n_bad++; $display("[TB] FAIL post_rst_ready: got %b want 1", cmd_ready); end
      n_cmp++; if (axis_full !== '0) begin n_bad++; $display("[TB] FAIL post_rst_full: got %0h want 0", axis_full); end
   endtask

   task automatic test_single_move();
      send(0, 16'h00FF, 11'd6, 1'b1, 1'b0);
      tick();
      n_cmp++; if (stepsOf(0) !== 11'd6) begin n_bad++; $display("[TB] FAIL single_steps: got %0d want 6", stepsOf(0)); end
      n_cmp++; if (mr_dir[0] !== 1'b1) begin n_bad++; $display("[TB] FAIL single_dir: got %b want 1", mr_dir[0]); end
      n_cmp++; if (divOf(0) !== 16'h00FF) begin n_bad++; $display("[TB] FAIL single_div: got %0h want ff", divOf(0)); end
      mr_active[0] = 1'b1;
      repeat (100) tick();
      n_cmp++; if (stepsOf(0) !== 11'd6) begin n_bad++; $display("[TB] FAIL single_hold: got %0d want 6", stepsOf(0)); end
      mr_active[0] = 1'b0;
      tick();
      n_cmp++; if (stepsOf(0) !== 11'd0) begin n_bad++; $display("[TB] FAIL single_end_steps: got %0d want 0", stepsOf(0)); end
      n_cmp++; if (axis_busy[0] !== 1'b1) begin n_bad++; $display("[TB] FAIL single_done_busy: got %b want 1", axis_busy[0]); end
      tick();
      n_cmp++; if (axis_busy[0] !== 1'b0) begin n_bad++; $display("[TB] FAIL single_idle_busy: got %b want 0", axis_busy[0]); end
   endtask

   task automatic test_back_to_back();
      send(3, 16'd100, 11'd10, 1'b0, 1'b0);
      tick();
      n_cmp++; if (stepsOf(3) !== 11'd10) begin n_bad++; $display("[TB] FAIL b2b_first: got %0d want 10", stepsOf(3)); end
      mr_active[3] = 1'b1;
      tick();
      send(3, 16'd200, 11'd20, 1'b1, 1'b0);
      n_cmp++; if (axis_full[3] !== 1'b1) begin n_bad++; $display("[TB] FAIL b2b_full: got %b want 1", axis_full[3]); end
      cmd_motor = 4'd3; cmd_divider = 16'd300; cmd_steps = 11'd30; cmd_dir = 1'b0; cmd_stop_on_term = 1'b0;
      cmd_valid = 1'b1;
      repeat (3) tick();
      n_cmp++; if (cmd_ready !== 1'b0) begin n_bad++; $display("[TB] FAIL b2b_stall: got %b want 0", cmd_ready); end
      n_cmp++; if (stepsOf(3) !== 11'd10) begin n_bad++; $display("[TB] FAIL b2b_running: got %0d want 10", stepsOf(3)); end
      mr_active[3] = 1'b0;
      tick();
      n_cmp++; if (cmd_ready !== 1'b1) begin n_bad++; $display("[TB] FAIL b2b_unstall: got %b want 1", cmd_ready); end
      n_cmp++; if (stepsOf(3) !== 11'd0) begin n_bad++; $display("[TB] FAIL b2b_end1: got %0d want 0", stepsOf(3)); end
      tick();
      cmd_valid = 1'b0;
      n_cmp++; if (axis_full[3] !== 1'b1) begin n_bad++; $display("[TB] FAIL b2b_refull: got %b want 1", axis_full[3]); end
      tick();
      n_cmp++; if (stepsOf(3) !== 11'd20) begin n_bad++; $display("[TB] FAIL b2b_second: got %0d want 20", stepsOf(3)); end
      n_cmp++; if (mr_dir[3] !== 1'b1) begin n_bad++; $display("[TB] FAIL b2b_dir2: got %b want 1", mr_dir[3]); end
      mr_active[3] = 1'b1;
      repeat (5) tick();
      mr_active[3] = 1'b0;
      repeat (3) tick();
      n_cmp++; if (stepsOf(3) !== 11'd30) begin n_bad++; $display("[TB] FAIL b2b_third: got %0d want 30", stepsOf(3)); end
      mr_active[3] = 1'b1;
      repeat (5) tick();
      mr_active[3] = 1'b0;
      repeat (2) tick();
      n_cmp++; if (axis_busy[3] !== 1'b0) begin n_bad++; $display("[TB] FAIL b2b_idle: got %b want 0", axis_busy[3]); end
   endtask

   task automatic test_limit_abort();
      logic seen;
      send(5, 16'd50, 11'd40, 1'b0, 1'b1);
      tick();
      mr_active[5] = 1'b1;
      tick();
      send(5, 16'd60, 11'd70, 1'b1, 1'b1);
      n_cmp++; if (axis_full[5] !== 1'b1) begin n_bad++; $display("[TB] FAIL abort_full: got %b want 1", axis_full[5]); end
      term_n[5] = 1'b0;
      seen = 1'b0;
      repeat (2) begin
         tick();
         if (mr_reset[5] || abort_pulse[5]) seen = 1'b1;
      end
      n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("[TB] FAIL abort_early: got %b want 0", seen); end
      tick();
      n_cmp++; if (mr_reset[5] !== 1'b1) begin n_bad++; $display("[TB] FAIL abort_mr_reset: got %b want 1", mr_reset[5]); end
      n_cmp++; if (abort_pulse[5] !== 1'b1) begin n_bad++; $display("[TB] FAIL abort_pulse: got %b want 1", abort_pulse[5]); end
      n_cmp++; if (stepsOf(5) !== 11'd0) begin n_bad++; $display("[TB] FAIL abort_steps: got %0d want 0", stepsOf(5)); end
      n_cmp++; if (axis_full[5] !== 1'b0) begin n_bad++; $display("[TB] FAIL abort_flush: got %b want 0", axis_full[5]); end
      mr_active[5] = 1'b0;
      term_n[5] = 1'b1;
      tick();
      n_cmp++; if ({mr_reset[5], abort_pulse[5]} !== 2'b00) begin n_bad++; $display("[TB] FAIL abort_once: got %b want 00", {mr_reset[5], abort_pulse[5]}); end
      n_cmp++; if (axis_busy[5] !== 1'b0) begin n_bad++; $display("[TB] FAIL abort_busy: got %b want 0", axis_busy[5]); end
      repeat (2) tick();
      n_cmp++; if (stepsOf(5) !== 11'd0) begin n_bad++; $display("[TB] FAIL abort_no_reload: got %0d want 0", stepsOf(5)); end
   endtask

   task automatic test_no_abort();
      logic seen;
      send(5, 16'd50, 11'd40, 1'b0, 1'b0);
      tick();
      mr_active[5] = 1'b1;
      tick();
      term_n[5] = 1'b0;
      seen = 1'b0;
      repeat (6) begin
         tick();
         if (mr_reset[5] || abort_pulse[5]) seen = 1'b1;
      end
      n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("[TB] FAIL noabort_pulse: got %b want 0", seen); end
      n_cmp++; if (stepsOf(5) !== 11'd40) begin n_bad++; $display("[TB] FAIL noabort_steps: got %0d want 40", stepsOf(5)); end
      term_n[5] = 1'b1;
      mr_active[5] = 1'b0;
      repeat (2) tick();
      n_cmp++; if (axis_busy[5] !== 1'b0) begin n_bad++; $display("[TB] FAIL noabort_idle: got %b want 0", axis_busy[5]); end
   endtask

   task automatic test_start_timeout();
      logic seen;
      send(1, 16'd7, 11'd4, 1'b0, 1'b0);
      seen = 1'b0;
      for (int k = 1; k <= 255; k++) begin
         tick();
         if (err_pulse) seen = 1'b1;
         if (k == 1) begin
            n_cmp++; if (stepsOf(1) !== 11'd4) begin n_bad++; $display("[TB] FAIL tmo_load: got %0d want 4", stepsOf(1)); end
         end
      end
      n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("[TB] FAIL tmo_early: got %b want 0", seen); end
      tick();
      n_cmp++; if (err_pulse !== 1'b1) begin n_bad++; $display("[TB] FAIL tmo_err: got %b want 1", err_pulse); end
      n_cmp++; if (stepsOf(1) !== 11'd0) begin n_bad++; $display("[TB] FAIL tmo_steps: got %0d want 0", stepsOf(1)); end
      n_cmp++; if (axis_busy[1] !== 1'b0) begin n_bad++; $display("[TB] FAIL tmo_idle: got %b want 0", axis_busy[1]); end
      tick();
      n_cmp++; if (err_pulse !== 1'b0) begin n_bad++; $display("[TB] FAIL tmo_err_len: got %b want 0", err_pulse); end
   endtask

   task automatic test_bad_index();
      cmd_motor = 4'd12; cmd_steps = 11'd5; cmd_valid = 1'b1;
      n_cmp++; if (cmd_ready !== 1'b1) begin n_bad++; $display("[TB] FAIL bad_ready: got %b want 1", cmd_ready); end
      tick();
      cmd_valid = 1'b0;
      n_cmp++; if (err_pulse !== 1'b1) begin n_bad++; $display("[TB] FAIL bad_err: got %b want 1", err_pulse); end
      n_cmp++; if (axis_busy !== '0) begin n_bad++; $display("[TB] FAIL bad_busy: got %0h want 0", axis_busy); end
      tick();
      n_cmp++; if (err_pulse !== 1'b0) begin n_bad++; $display("[TB] FAIL bad_err_len: got %b want 0", err_pulse); end
   endtask

   task automatic test_zero_steps();
      send(4, 16'd9, 11'd0, 1'b1, 1'b0);
      n_cmp++; if (axis_busy[4] !== 1'b1) begin n_bad++; $display("[TB] FAIL zero_queued: got %b want 1", axis_busy[4]); end
      tick();
      n_cmp++; if (axis_busy[4] !== 1'b0) begin n_bad++; $display("[TB] FAIL zero_popped: got %b want 0", axis_busy[4]); end
      tick();
      n_cmp++; if ({mr_dir[4], stepsOf(4)} !== 12'd0) begin n_bad++; $display("[TB] FAIL zero_no_load: got %0h want 0", {mr_dir[4], stepsOf(4)}); end
   endtask

   task automatic test_push_pop();
      send(2, 16'd11, 11'd5, 1'b0, 1'b0);
      tick();
      mr_active[2] = 1'b1;
      tick();
      cmd_motor = 4'd2; cmd_divider = 16'd12; cmd_steps = 11'd8; cmd_dir = 1'b1; cmd_stop_on_term = 1'b0;
      cmd_valid = 1'b1;
      mr_active[2] = 1'b0;
      n_cmp++; if (cmd_ready !== 1'b1) begin n_bad++; $display("[TB] FAIL pp_ready: got %b want 1", cmd_ready); end
      tick();
      cmd_valid = 1'b0;
      n_cmp++; if ({axis_full[2], axis_busy[2]} !== 2'b01) begin n_bad++; $display("[TB] FAIL pp_count: got %b want 01", {axis_full[2], axis_busy[2]}); end
      send(2, 16'd13, 11'd9, 1'b0, 1'b0);
      n_cmp++; if (axis_full[2] !== 1'b1) begin n_bad++; $display("[TB] FAIL pp_full: got %b want 1", axis_full[2]); end
      tick();
      n_cmp++; if (stepsOf(2) !== 11'd8) begin n_bad++; $display("[TB] FAIL pp_order1: got %0d want 8", stepsOf(2)); end
      mr_active[2] = 1'b1;
      tick();
      mr_active[2] = 1'b0;
      repeat (3) tick();
      n_cmp++; if (stepsOf(2) !== 11'd9) begin n_bad++; $display("[TB] FAIL pp_order2: got %0d want 9", stepsOf(2)); end
      mr_active[2] = 1'b1;
      tick();
      mr_active[2] = 1'b0;
      repeat (2) tick();
      n_cmp++; if (axis_busy[2] !== 1'b0) begin n_bad++; $display("[TB] FAIL pp_idle: got %b want 0", axis_busy[2]); end
   endtask

   task automatic test_async_reset();
      send(0, 16'd10, 11'd100, 1'b1, 1'b0);
      send(9, 16'd20, 11'd200, 1'b1, 1'b0);
      send(9, 16'd30, 11'd300, 1'b0, 1'b0);
      mr_active[0] = 1'b1;
      mr_active[9] = 1'b1;
      repeat (2) tick();
      n_cmp++; if ({stepsOf(0), stepsOf(9)} !== {11'd100, 11'd200}) begin n_bad++; $display("[TB] FAIL ar_running: got %0d/%0d want 100/200", stepsOf(0), stepsOf(9)); end
      #3 reset_n = 1'b0;
      #1;
      n_cmp++; if (mr_steps !== '0) begin n_bad++; $display("[TB] FAIL ar_steps: got %0h want 0", mr_steps); end
      n_cmp++; if ({mr_dir, mr_reset, abort_pulse} !== '0) begin n_bad++; $display("[TB] FAIL ar_ctl: got %0h want 0", {mr_dir, mr_reset, abort_pulse}); end
      n_cmp++; if (mr_divider !== '0) begin n_bad++; $display("[TB] FAIL ar_div: got %0h want 0", mr_divider); end
      n_cmp++; if ({axis_busy, axis_full, cmd_ready, err_pulse} !== '0) begin n_bad++; $display("[TB] FAIL ar_status: got %0h want 0", {axis_busy, axis_full, cmd_ready, err_pulse}); end
      mr_active = '0;
      repeat (2) tick();
      reset_n = 1'b1;
      tick();
      n_cmp++; if (axis_busy !== '0) begin n_bad++; $display("[TB] FAIL ar_rel_busy: got %0h want 0", axis_busy); end
      repeat (3) tick();
      n_cmp++; if ({axis_busy, mr_steps} !== '0) begin n_bad++; $display("[TB] FAIL ar_empty: got %0h want 0", {axis_busy, mr_steps}); end
   endtask

   initial begin
      test_reset();
      test_single_move();
      test_back_to_back();
      test_limit_abort();
      test_no_abort();
      test_start_timeout();
      test_bad_index();
      test_zero_steps();
      test_push_pop();
      test_async_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached, want completion");
      $fatal(1, "[TB] watchdog");
   end

endmodule
